// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Forwarding and load-use hazard unit for the pipelined CPU. Tracks the
//   destination records of instructions from EX through the last producer
//   stage that can forward. It produces per-operand bypass selects for EX and
//   a load-use stall request for IF/ID. The unit also keeps a saturating count
//   of load-use stall cycles.
//
// Ports
//   clk_i, rst_i     clock, asynchronous active-high reset
//   stall_i          global freeze from the cache; every record and the counter hold
//   flush_i          squash the ID instruction (taken branch); EX receives a bubble
//   id_rs_i          ID source addresses, operand j at [j*ADDR_W +: ADDR_W]
//   id_rs_used_i     bit j set when source j is really read
//   id_rd_i          ID destination address
//   id_regwrite_i    ID instruction writes the register file
//   id_memread_i     ID instruction is a load
//   fwd_sel_o        per EX operand: 0 = register file, k = producer stage k
//   hazard_stall_o   load-use stall request (hold PC and IF/ID)
//   stall_cnt_o      saturating count of load-use stall cycles
module fwd_hazard_unit #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int SEL_W   = $clog2(DEPTH + 1),
  parameter int CNT_W   = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        stall_i,
  input  logic                        flush_i,
  input  logic [NUM_SRC*ADDR_W-1:0]   id_rs_i,
  input  logic [NUM_SRC-1:0]          id_rs_used_i,
  input  logic [ADDR_W-1:0]           id_rd_i,
  input  logic                        id_regwrite_i,
  input  logic                        id_memread_i,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel_o,
  output logic                        hazard_stall_o,
  output logic [CNT_W-1:0]            stall_cnt_o
);

  // Source fields and the load flag matter only while a record sits in EX.
  // The producer stages therefore carry just rd and regwrite. This is
  // externally identical to shifting the whole record down the pipe.
  logic [NUM_SRC*ADDR_W-1:0] exRs;
  logic [NUM_SRC-1:0]        exRsUsed;
  logic                      exMemRead;
  logic [ADDR_W-1:0]         recRd [DEPTH+1];
  logic [DEPTH:0]            recRegWrite;

  logic [CNT_W-1:0]          stallCnt;
  logic [NUM_SRC*SEL_W-1:0]  fwdSel;
  logic                      rsMatch;
  logic                      hazard;

  // Scan from the oldest producer down to the youngest so that the youngest
  // match overwrites older ones.
  always_comb begin
    fwdSel = '0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      for (int unsigned k = DEPTH; k >= 1; k--) begin
        if (recRegWrite[k] && (recRd[k] != '0) && exRsUsed[j] &&
            (recRd[k] == exRs[j*ADDR_W +: ADDR_W])) begin
          fwdSel[j*SEL_W +: SEL_W] = SEL_W'(k);
        end
      end
    end
  end

  always_comb begin
    rsMatch = 1'b0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      if (id_rs_used_i[j] && (id_rs_i[j*ADDR_W +: ADDR_W] == recRd[0])) begin
        rsMatch = 1'b1;
      end
    end
  end

  assign hazard = exMemRead & recRegWrite[0] & (recRd[0] != '0) & rsMatch;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k <= DEPTH; k++) begin
        recRd[k] <= '0;
      end
      recRegWrite <= '0;
      exRs        <= '0;
      exRsUsed    <= '0;
      exMemRead   <= 1'b0;
      stallCnt    <= '0;
    end else if (!stall_i) begin
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        recRd[k]       <= recRd[k-1];
        recRegWrite[k] <= recRegWrite[k-1];
      end
      if (hazard || flush_i) begin
        recRd[0]       <= '0;
        recRegWrite[0] <= 1'b0;
        exRs           <= '0;
        exRsUsed       <= '0;
        exMemRead      <= 1'b0;
      end else begin
        recRd[0]       <= id_rd_i;
        recRegWrite[0] <= id_regwrite_i;
        exRs           <= id_rs_i;
        exRsUsed       <= id_rs_used_i;
        exMemRead      <= id_memread_i;
      end
      if (hazard && (stallCnt != '1)) begin
        stallCnt <= stallCnt + CNT_W'(1);
      end
    end
  end

  assign fwd_sel_o      = fwdSel;
  assign hazard_stall_o = hazard;
  assign stall_cnt_o    = stallCnt;

endmodule
